// File: rtl/fifo_ctrl_pkg.sv
// Shared constants for the FIFO command stage: FSM encoding, reject counter limit
// and the saturating increment used on the reject counter.
package fifo_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t WRITE  = 2'd1;
    localparam state_t READ   = 2'd2;
    localparam state_t SETTLE = 2'd3;

    localparam logic [7:0] REJ_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        if (value == REJ_MAX) begin
            return REJ_MAX;
        end else begin
            return value + 8'd1;
        end
    endfunction

endpackage

// File: rtl/debounce_edge.sv
// Pushbutton conditioner: two-flop synchroniser, stability counter and
// a one-cycle pulse on each accepted press (releases produce nothing).
module debounce_edge #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_WIDTH       = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 sync1_r;
    logic                 sync2_r;
    logic                 level_r;
    logic                 rise_r;
    logic [CNT_WIDTH-1:0] cnt_r;

    // Bring the raw button into the clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new level only after it has held for the full window; any glitch back restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            cnt_r   <= {CNT_WIDTH{1'b0}};
        end else if (sync2_r != level_r) begin
            if (cnt_r == CNT_LAST) begin
                level_r <= sync2_r;
                rise_r  <= sync2_r;
                cnt_r   <= {CNT_WIDTH{1'b0}};
            end else begin
                level_r <= level_r;
                rise_r  <= 1'b0;
                cnt_r   <= cnt_r + CNT_ONE;
            end
        end else begin
            level_r <= level_r;
            rise_r  <= 1'b0;
            cnt_r   <= {CNT_WIDTH{1'b0}};
        end
    end

    assign level = level_r;
    assign rise  = rise_r;

endmodule

// File: rtl/fifo_input_ctrl.sv
// Board-level command stage for synchronous_fifo: turns debounced button presses into
// single wr/rd strobes, guards against full/empty and counts rejected presses.
module fifo_input_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_WIDTH       = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_wr,
    input  logic                  btn_rd,
    input  logic [DATA_WIDTH-1:0] sw_data,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    output logic                  wr,
    output logic                  rd,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic [7:0]            rej_count
);

    logic req_wr_s;
    logic req_rd_s;
    logic lvl_wr_s;
    logic lvl_rd_s;
    logic unused_lvl_s;

    debounce_edge #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_db_wr (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_wr),
        .level (lvl_wr_s),
        .rise  (req_wr_s)
    );

    debounce_edge #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_db_rd (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_rd),
        .level (lvl_rd_s),
        .rise  (req_rd_s)
    );

    // Debounced levels are kept for board visibility only.
    assign unused_lvl_s = lvl_wr_s ^ lvl_rd_s;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    pend_r;
    logic                    pend_nxt_s;
    logic                    wr_r;
    logic                    wr_nxt_s;
    logic                    rd_r;
    logic                    rd_nxt_s;
    logic                    busy_r;
    logic [DATA_WIDTH-1:0]   data_r;
    logic [DATA_WIDTH-1:0]   data_nxt_s;
    logic [7:0]              rej_r;
    logic [7:0]              rej_nxt_s;

    // Next-state decode; writes win over reads, reads seen while busy are remembered in pend.
    always_comb begin
        state_nxt_s = state_r;
        pend_nxt_s  = pend_r;
        wr_nxt_s    = 1'b0;
        rd_nxt_s    = 1'b0;
        data_nxt_s  = data_r;
        rej_nxt_s   = rej_r;
        case (state_r)
            IDLE: begin
                if (req_wr_s) begin
                    if (req_rd_s) begin
                        pend_nxt_s = 1'b1;
                    end else begin
                        pend_nxt_s = pend_r;
                    end
                    if (!fifo_full) begin
                        data_nxt_s  = sw_data;
                        wr_nxt_s    = 1'b1;
                        state_nxt_s = WRITE;
                    end else begin
                        rej_nxt_s = sat_inc(rej_r);
                    end
                end else if (req_rd_s || pend_r) begin
                    pend_nxt_s = 1'b0;
                    if (!fifo_empty) begin
                        rd_nxt_s    = 1'b1;
                        state_nxt_s = READ;
                    end else begin
                        rej_nxt_s = sat_inc(rej_r);
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WRITE, READ: begin
                state_nxt_s = SETTLE;
                pend_nxt_s  = pend_r | req_rd_s;
            end
            SETTLE: begin
                state_nxt_s = IDLE;
                pend_nxt_s  = pend_r | req_rd_s;
            end
            default: begin
                state_nxt_s = IDLE;
                pend_nxt_s  = 1'b0;
            end
        endcase
    end

    // Register the FSM and every output so strobes are glitch-free at the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            pend_r  <= 1'b0;
            wr_r    <= 1'b0;
            rd_r    <= 1'b0;
            busy_r  <= 1'b0;
            data_r  <= {DATA_WIDTH{1'b0}};
            rej_r   <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            pend_r  <= pend_nxt_s;
            wr_r    <= wr_nxt_s;
            rd_r    <= rd_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
            data_r  <= data_nxt_s;
            rej_r   <= rej_nxt_s;
        end
    end

    assign wr        = wr_r;
    assign rd        = rd_r;
    assign busy      = busy_r;
    assign data_in   = data_r;
    assign rej_count = rej_r;

endmodule

// File: tb/tb_fifo_input_ctrl.sv
// Directed bench for fifo_input_ctrl with a cycle-index based reference model
// and an 8-deep FIFO occupancy plant driving fifo_full/fifo_empty.
module tb_fifo_input_ctrl;

    localparam int DW    = 8;
    localparam int D     = 4;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          btn_wr = 1'b0;
    logic          btn_rd = 1'b0;
    logic [DW-1:0] sw_data = 8'h00;
    logic          fifo_full;
    logic          fifo_empty;
    logic          wr;
    logic          rd;
    logic          busy;
    logic [DW-1:0] data_in;
    logic [7:0]    rej_count;

    int   occ = 0;
    int   occ_next = 0;
    logic force_full = 1'b0;
    logic force_empty = 1'b0;

    assign fifo_full  = force_full || (occ >= DEPTH);
    assign fifo_empty = force_empty || (occ == 0);

    always #5 clk = ~clk;

    fifo_input_ctrl #(
        .DATA_WIDTH      (DW),
        .DEBOUNCE_CYCLES (D),
        .CNT_WIDTH       (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_wr     (btn_wr),
        .btn_rd     (btn_rd),
        .sw_data    (sw_data),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .wr         (wr),
        .rd         (rd),
        .data_in    (data_in),
        .busy       (busy),
        .rej_count  (rej_count)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a press is accepted when the last D raw samples (delayed by the
    // two synchroniser stages) all disagree with the debounced level. The controller is
    // free for a new decision 3 edges after accepting one.
    int            k = 0;
    int            free_at = 0;
    logic          wr_exp = 1'b0;
    logic          rd_exp = 1'b0;
    logic          busy_exp = 1'b0;
    logic [DW-1:0] data_exp = 8'h00;
    logic [7:0]    rej_exp = 8'h00;
    logic          pend = 1'b0;
    logic          rise_w = 1'b0;
    logic          rise_r = 1'b0;
    logic          lvl_w = 1'b0;
    logic          lvl_r = 1'b0;
    logic [D+1:0]  hist_w = '0;
    logic [D+1:0]  hist_r = '0;

    function automatic logic [1:0] deb_step(input logic [D+1:0] h, input logic lvl);
        logic [D-1:0] win;
        win = h[D+1:2];
        if (win == {D{~lvl}}) return {~lvl, ~lvl};
        else return {lvl, 1'b0};
    endfunction

    initial forever begin
        logic req_w;
        logic req_r;
        @(posedge clk or posedge reset);
        if (reset) begin
            free_at = 0; wr_exp = 1'b0; rd_exp = 1'b0; busy_exp = 1'b0;
            data_exp = '0; rej_exp = 8'h00; pend = 1'b0;
            rise_w = 1'b0; rise_r = 1'b0; lvl_w = 1'b0; lvl_r = 1'b0;
            hist_w = '0; hist_r = '0; occ = 0; occ_next = 0;
        end else begin
            k++;
            occ_next = occ + (wr_exp ? 1 : 0) - (rd_exp ? 1 : 0);
            req_w = rise_w;
            req_r = rise_r;
            wr_exp = 1'b0;
            rd_exp = 1'b0;
            if (k >= free_at) begin
                if (req_w) begin
                    if (req_r) pend = 1'b1;
                    if (!fifo_full) begin
                        wr_exp = 1'b1; data_exp = sw_data; free_at = k + 3;
                    end else if (rej_exp != 8'hFF) rej_exp++;
                end else if (req_r || pend) begin
                    pend = 1'b0;
                    if (!fifo_empty) begin
                        rd_exp = 1'b1; free_at = k + 3;
                    end else if (rej_exp != 8'hFF) rej_exp++;
                end
            end else if (req_r) begin
                pend = 1'b1;
            end
            busy_exp = (k + 1 < free_at);
            hist_w = {hist_w[D:0], btn_wr};
            hist_r = {hist_r[D:0], btn_rd};
            {lvl_w, rise_w} = deb_step(hist_w, lvl_w);
            {lvl_r, rise_r} = deb_step(hist_r, lvl_r);
        end
    end

    // Per-cycle comparison against the model, strobe bookkeeping and FIFO plant update.
    int   cyc = 0;
    int   wr_cnt = 0;
    int   rd_cnt = 0;
    int   last_wr_cyc = -100;
    int   last_rd_cyc = -100;
    logic prev_strobe = 1'b0;

    initial forever begin
        @(negedge clk);
        cyc++;
        chk("wr", {31'd0, wr}, {31'd0, wr_exp});
        chk("rd", {31'd0, rd}, {31'd0, rd_exp});
        chk("busy", {31'd0, busy}, {31'd0, busy_exp});
        chk("data_in", {24'd0, data_in}, {24'd0, data_exp});
        chk("rej_count", {24'd0, rej_count}, {24'd0, rej_exp});
        chk("strobe_spacing", {30'd0, wr & rd, prev_strobe & (wr | rd)}, 32'd0);
        if (wr === 1'b1) begin wr_cnt++; last_wr_cyc = cyc; end
        if (rd === 1'b1) begin rd_cnt++; last_rd_cyc = cyc; end
        prev_strobe = wr | rd;
        occ = occ_next;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        tick(1);
        #1 reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic press(input logic w, input logic r, input int hi, input int lo);
        btn_wr = w; btn_rd = r;
        tick(hi);
        btn_wr = 1'b0; btn_rd = 1'b0;
        tick(lo);
    endtask

    initial begin
        int w0;
        int r0;
        int c0;
        // 1: reset state and quiet idle
        #1 reset = 1'b1;
        tick(3);
        chk("t1_reset_outputs", {wr, rd, busy, data_in, rej_count}, 32'd0);
        reset = 1'b0;
        w0 = wr_cnt; r0 = rd_cnt;
        tick(50);
        chk("t1_no_strobes", wr_cnt + rd_cnt - w0 - r0, 32'd0);

        // 2: bounces ignored, a real press gives one write of A3 seven clocks later
        sw_data = 8'hA3;
        w0 = wr_cnt;
        repeat (2) press(1'b1, 1'b0, 3, 3);
        chk("t2_bounce_only", wr_cnt - w0, 32'd0);
        c0 = cyc;
        press(1'b1, 1'b0, 20, 20);
        chk("t2_one_wr", wr_cnt - w0, 32'd1);
        chk("t2_latency", last_wr_cyc - c0, 32'd7);
        chk("t2_data_in", {24'd0, data_in}, 32'h0000_00A3);

        // 3: simultaneous press on an empty FIFO: write first, read after settle
        do_reset();
        sw_data = 8'h3C;
        w0 = wr_cnt; r0 = rd_cnt;
        press(1'b1, 1'b1, 20, 20);
        chk("t3_one_wr", wr_cnt - w0, 32'd1);
        chk("t3_one_rd", rd_cnt - r0, 32'd1);
        chk("t3_gap", last_rd_cyc - last_wr_cyc, 32'd3);
        chk("t3_no_reject", {24'd0, rej_count}, 32'd0);

        // 4: rejects on full, then saturation on empty
        force_full = 1'b1;
        w0 = wr_cnt;
        repeat (3) press(1'b1, 1'b0, 10, 10);
        chk("t4_no_wr", wr_cnt - w0, 32'd0);
        chk("t4_rej3", {24'd0, rej_count}, 32'd3);
        force_full = 1'b0;
        force_empty = 1'b1;
        r0 = rd_cnt;
        repeat (300) press(1'b0, 1'b1, 10, 10);
        chk("t4_no_rd", rd_cnt - r0, 32'd0);
        chk("t4_rej_sat", {24'd0, rej_count}, 32'd255);
        force_empty = 1'b0;

        // 5: async reset aborts a write; held button yields one write after release
        do_reset();
        sw_data = 8'h5A;
        btn_wr = 1'b1;
        for (int i = 0; i < 30 && wr !== 1'b1; i++) tick(1);
        chk("t5_wr_seen", {31'd0, wr}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("t5_wr_aborted", {31'd0, wr}, 32'd0);
        chk("t5_data_cleared", {24'd0, data_in}, 32'd0);
        tick(2);
        reset = 1'b0;
        w0 = wr_cnt;
        tick(30);
        btn_wr = 1'b0;
        tick(20);
        chk("t5_one_wr_after_reset", wr_cnt - w0, 32'd1);
        chk("t5_data_in", {24'd0, data_in}, 32'h0000_005A);

        // 6: fill the 8-deep FIFO then read one more than it holds
        do_reset();
        w0 = wr_cnt; r0 = rd_cnt;
        for (int i = 1; i <= 8; i++) begin
            sw_data = 8'(i);
            press(1'b1, 1'b0, 10, 10);
        end
        chk("t6_eight_wr", wr_cnt - w0, 32'd8);
        chk("t6_last_data", {24'd0, data_in}, 32'h0000_0008);
        repeat (9) press(1'b0, 1'b1, 10, 10);
        chk("t6_eight_rd", rd_cnt - r0, 32'd8);
        chk("t6_rej1", {24'd0, rej_count}, 32'd1);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
